// File: rtl/collatz_sweep_ctrl_if.sv
// Bundle of config, engine and result signals between the sweep controller and its neighbours.
// master = controller side, slave = host/engine/consumer side.
interface collatz_sweep_ctrl_if #(
    parameter int STEP_W = 10
);
    logic              cfg_start;
    logic [15:0]       cfg_first;
    logic [15:0]       cfg_last;
    logic              cfg_abort;
    logic              busy;
    logic              done;
    logic              err;
    logic              eng_st;
    logic [15:0]       eng_co;
    logic [19:0]       eng_k;
    logic              eng_bs;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_co;
    logic [STEP_W-1:0] res_steps;
    logic [19:0]       res_peak;
    logic [STEP_W-1:0] max_steps;
    logic [15:0]       max_co;

    modport master (
        input  cfg_start, cfg_first, cfg_last, cfg_abort, eng_k, eng_bs, res_ready,
        output busy, done, err, eng_st, eng_co, res_valid, res_co, res_steps, res_peak,
               max_steps, max_co
    );

    modport slave (
        output cfg_start, cfg_first, cfg_last, cfg_abort, eng_k, eng_bs, res_ready,
        input  busy, done, err, eng_st, eng_co, res_valid, res_co, res_steps, res_peak,
               max_steps, max_co
    );
endinterface

// File: rtl/collatz_sweep_ctrl.sv
// Walks the Collatz engine over [cfg_first..cfg_last], one run per value, and streams
// steps/peak per value plus a running max-steps summary.
module collatz_sweep_ctrl #(
    parameter int STEP_W   = 10,
    parameter int START_TO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    collatz_sweep_ctrl_if.master bus
);
    localparam int                TO_W    = $clog2(START_TO + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(START_TO - 1);
    localparam logic [STEP_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BS, RUN, REPORT, DRAIN, FIN
    } state_t;

    state_t            state, state_nx;
    logic [15:0]       cur, last;
    logic [STEP_W-1:0] cnt, steps, max_steps_q;
    logic [15:0]       max_co_q;
    logic [19:0]       peak;
    logic [TO_W-1:0]   to;
    logic              err_q, abort_q;

    logic bad_range, start_ok, abort_any, last_val;

    assign bad_range = (bus.cfg_first == 16'd0) || (bus.cfg_first > bus.cfg_last);
    assign abort_any = bus.cfg_abort || abort_q;
    assign last_val  = (cur == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        case (state)
            IDLE: begin
                // an engine left running by a mid-run reset must finish before a new sweep
                if (bus.cfg_start && !bus.eng_bs) begin
                    start_ok = 1'b1;
                    state_nx = bad_range ? FIN : LAUNCH;
                end
            end
            LAUNCH:  state_nx = WAIT_BS;
            WAIT_BS: begin
                if (bus.eng_bs)        state_nx = abort_any ? DRAIN : RUN;
                else if (to == TO_LAST) state_nx = FIN;
            end
            RUN: begin
                if (!bus.eng_bs)   state_nx = abort_any ? FIN : REPORT;
                else if (abort_any) state_nx = DRAIN;
            end
            REPORT: begin
                if (bus.res_ready) state_nx = (abort_any || last_val) ? FIN : LAUNCH;
            end
            DRAIN:   if (!bus.eng_bs) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= '0;
            last        <= '0;
            cnt         <= '0;
            steps       <= '0;
            peak        <= '0;
            to          <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            max_steps_q <= '0;
            max_co_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cur         <= bus.cfg_first;
                        last        <= bus.cfg_last;
                        err_q       <= bad_range;
                        abort_q     <= 1'b0;
                        max_steps_q <= '0;
                        max_co_q    <= '0;
                    end
                end
                LAUNCH: begin
                    cnt  <= '0;
                    peak <= {4'b0, cur};
                    to   <= '0;
                end
                WAIT_BS: begin
                    // the load cycle counts as one but eng_k is not yet meaningful
                    if (bus.eng_bs) cnt <= STEP_W'(1);
                    else begin
                        to <= to + 1'b1;
                        if (to == TO_LAST) err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.eng_bs) begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        if (bus.eng_k > peak) peak <= bus.eng_k;
                    end else begin
                        steps <= (cnt == CNT_MAX) ? CNT_MAX : cnt - 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        // strict compare keeps the earlier (lower) co on ties
                        if (steps > max_steps_q) begin
                            max_steps_q <= steps;
                            max_co_q    <= cur;
                        end
                        if (!(abort_any || last_val)) cur <= cur + 1'b1;
                    end
                end
                default: ;
            endcase
            if (state != IDLE && bus.cfg_abort) abort_q <= 1'b1;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.err       = err_q;
    assign bus.eng_st    = (state == LAUNCH);
    assign bus.eng_co    = cur;
    assign bus.res_valid = (state == REPORT);
    assign bus.res_co    = cur;
    assign bus.res_steps = steps;
    assign bus.res_peak  = peak;
    assign bus.max_steps = max_steps_q;
    assign bus.max_co    = max_co_q;
endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Directed bench for collatz_sweep_ctrl: behavioural engine, arithmetic Collatz model and
// a per-cycle compare process over results, launches, latencies and the sweep summary.
module tb_collatz_sweep_ctrl;
    localparam int STEP_W   = 10;
    localparam int START_TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    collatz_sweep_ctrl_if #(.STEP_W(STEP_W)) bus ();
    collatz_sweep_ctrl #(.STEP_W(STEP_W), .START_TO(START_TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // engine model: not reset by rst_n, loads co one cycle after st, one iteration per cycle
    logic        eng_dead = 1'b0;
    logic [19:0] ek  = '0;
    logic        ebs = 1'b0;
    always @(posedge clk) begin
        if (bus.eng_st && !eng_dead) begin
            ebs <= 1'b1;
            ek  <= {4'b0, bus.eng_co};
        end else if (ebs) begin
            if (ek == 20'd1) ebs <= 1'b0;
            else             ek  <= ek[0] ? ek * 3 + 1 : ek >> 1;
        end
    end
    assign bus.eng_k  = ek;
    assign bus.eng_bs = ebs;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int co; int steps; int peak; } exp_t;
    exp_t q[$];

    int  checks = 0, errors = 0;
    int  mdl_max, mdl_maxco, exp_launch, st_cnt, st_cyc, start_cyc, done_cyc, bs_fall_cyc, hs_cyc;
    bit  exp_err, rv_seen, done_seen, hs_pending, prev_bs, prev_rv;

    function automatic int mdl_steps(int n);
        longint v = n;
        int s = 0;
        while (v != 1) begin
            v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
            s++;
        end
        return s;
    endfunction

    function automatic int mdl_peak(int n);
        longint v = n;
        longint p = n;
        while (v != 1) begin
            v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
            if (v > p) p = v;
        end
        return int'(p);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_range(input int f, input int l);
        exp_t e;
        for (int n = f; n <= l; n++) begin
            e.co = n; e.steps = mdl_steps(n); e.peak = mdl_peak(n);
            q.push_back(e);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_bs && !bus.eng_bs) bs_fall_cyc = cyc;
                prev_bs = bus.eng_bs;
                if (bus.eng_st) begin
                    st_cnt++;
                    st_cyc = cyc;
                    chk("eng_co", bus.eng_co, exp_launch);
                    exp_launch++;
                    if (hs_pending) chk("hs_to_st_latency", cyc, hs_cyc + 1);
                    hs_pending = 0;
                end
                if (bus.res_valid) begin
                    rv_seen = 1;
                    if (!prev_rv) chk("bs_to_valid_latency", cyc, bs_fall_cyc + 1);
                    chk("result_expected", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        chk("res_co", bus.res_co, q[0].co);
                        chk("res_steps", bus.res_steps, q[0].steps);
                        chk("res_peak", bus.res_peak, q[0].peak);
                        if (bus.res_ready) begin
                            if (q[0].steps > mdl_max) begin
                                mdl_max = q[0].steps;
                                mdl_maxco = q[0].co;
                            end
                            void'(q.pop_front());
                            hs_cyc = cyc;
                            hs_pending = 1;
                        end
                    end
                end
                prev_rv = bus.res_valid;
                if (bus.done) begin
                    done_seen = 1;
                    done_cyc = cyc;
                    chk("max_steps", bus.max_steps, mdl_max);
                    chk("max_co", bus.max_co, mdl_maxco);
                    chk("err_at_done", bus.err, exp_err);
                    chk("results_left", q.size(), 0);
                    chk("busy_at_done", bus.busy, 1);
                end
            end
        end
    endtask

    task automatic start_sweep(input logic [15:0] f, input logic [15:0] l, input bit e);
        mdl_max = 0; mdl_maxco = 0; exp_err = e; exp_launch = f;
        st_cnt = 0; rv_seen = 0; done_seen = 0; hs_pending = 0;
        @(posedge clk); #1;
        bus.cfg_first = f; bus.cfg_last = l; bus.cfg_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_seen, 1);
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
    endtask

    task automatic wait_bs(input bit lvl, input int budget);
        int n = 0;
        while (bus.eng_bs != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("eng_bs_level", bus.eng_bs, lvl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bus.cfg_start = 1'b0; bus.cfg_first = '0; bus.cfg_last = '0;
        bus.cfg_abort = 1'b0; bus.res_ready = 1'b1;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_eng_st", bus.eng_st, 0);
        chk("rst_eng_co", bus.eng_co, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_max_steps", bus.max_steps, 0);
        chk("rst_max_co", bus.max_co, 0);

        // pin the model against hand-computed values
        chk("mdl_steps3", mdl_steps(3), 7);
        chk("mdl_peak3", mdl_peak(3), 16);
        chk("mdl_steps1", mdl_steps(1), 0);
        chk("mdl_steps6", mdl_steps(6), 8);
        chk("mdl_peak6", mdl_peak(6), 16);
        chk("mdl_steps9", mdl_steps(9), 19);
        chk("mdl_peak9", mdl_peak(9), 52);

        // single value 3
        push_range(3, 3);
        start_sweep(3, 3, 0);
        wait_done(200);
        chk("t3_eng_st_count", st_cnt, 1);
        chk("t3_max_steps", bus.max_steps, 7);
        chk("t3_max_co", bus.max_co, 3);
        chk("t3_err", bus.err, 0);

        // single value 1: one-cycle engine run
        push_range(1, 1);
        start_sweep(1, 1, 0);
        wait_done(200);
        chk("t1_eng_st_count", st_cnt, 1);
        chk("t1_max_steps", bus.max_steps, 0);

        // 1..10 with a stray cfg_start while busy
        push_range(1, 10);
        start_sweep(1, 10, 0);
        repeat (3) @(posedge clk);
        #1 bus.cfg_first = 16'd100; bus.cfg_last = 16'd100; bus.cfg_start = 1'b1;
        @(posedge clk); #1 bus.cfg_start = 1'b0;
        wait_done(2000);
        chk("t10_eng_st_count", st_cnt, 10);
        chk("t10_max_steps", bus.max_steps, 19);
        chk("t10_max_co", bus.max_co, 9);

        // bad ranges
        start_sweep(0, 3, 1);
        wait_done(20);
        chk("zero_done_latency", done_cyc, start_cyc + 1);
        chk("zero_eng_st", st_cnt, 0);
        chk("zero_res_valid", rv_seen, 0);
        start_sweep(5, 4, 1);
        wait_done(20);
        chk("rev_done_latency", done_cyc, start_cyc + 1);
        chk("rev_eng_st", st_cnt, 0);
        chk("rev_res_valid", rv_seen, 0);
        chk("rev_err_sticky", bus.err, 1);

        // consumer stall on co=6
        bus.res_ready = 1'b0;
        push_range(6, 6);
        start_sweep(6, 6, 0);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("stall_valid_held", bus.res_valid, 1);
        chk("stall_no_relaunch", st_cnt, 1);
        @(posedge clk); #1 bus.res_ready = 1'b1;
        wait_done(100);
        chk("stall_max_steps", bus.max_steps, 8);
        chk("stall_err_cleared", bus.err, 0);

        // engine never starts
        eng_dead = 1'b1;
        start_sweep(5, 5, 1);
        wait_done(50);
        chk("to_done_latency", done_cyc, st_cyc + START_TO + 1);
        chk("to_res_valid", rv_seen, 0);
        eng_dead = 1'b0;

        // abort during the co=27 run
        start_sweep(27, 28, 0);
        wait_bs(1'b1, 20);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 bus.cfg_abort = 1'b1;
        wait_done(400);
        bus.cfg_abort = 1'b0;
        chk("abort_done_latency", done_cyc, bs_fall_cyc + 1);
        chk("abort_eng_st_count", st_cnt, 1);
        chk("abort_res_valid", rv_seen, 0);

        // reset mid-run: engine keeps going, start must be ignored until it idles
        start_sweep(27, 27, 0);
        wait_bs(1'b1, 20);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        st_cnt = 0;
        bus.cfg_first = 16'd3; bus.cfg_last = 16'd3; bus.cfg_start = 1'b1;
        @(posedge clk); #1 bus.cfg_start = 1'b0;
        @(negedge clk);
        chk("rstrun_busy", bus.busy, 0);
        @(negedge clk);
        chk("rstrun_eng_st", st_cnt, 0);
        wait_bs(1'b0, 400);
        push_range(3, 3);
        start_sweep(3, 3, 0);
        wait_done(200);
        chk("rstrun_recover_max", bus.max_steps, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
